// File: rtl/rs_syndrome_check_stream.sv
// Streaming Reed-Solomon syndrome checker over GF(2^8). It folds each input beat into
// S_j = c(alpha^j) with a Horner update and keeps saturating frame/error statistics.
module rs_syndrome_check_stream #(
    parameter int         N_SYMS    = 10,
    parameter int         NSYM      = 2,
    parameter int         BEAT_SYMS = 2,
    parameter logic [8:0] PRIM_POLY = 9'h15F,
    parameter int         CNT_W     = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear_in,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [BEAT_SYMS*8-1:0] in_data,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [NSYM*8-1:0]      syndrome_out,
    output logic                   error_flag_out,
    output logic                   frame_err_out,
    output logic [CNT_W-1:0]       err_cnt_out,
    output logic [CNT_W-1:0]       cw_cnt_out
);
    // state | meaning
    // ACCUM | collecting beats of the current codeword
    // HOLD  | result presented, waiting for out_ready

    localparam int BEATS = N_SYMS / BEAT_SYMS;
    localparam int BC_W  = $clog2(BEATS + 1);

    if ((N_SYMS % BEAT_SYMS) != 0) begin : g_bad_beat
        $error("N_SYMS must be a multiple of BEAT_SYMS");
    end

    typedef enum logic {ACCUM, HOLD} state_t;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ PRIM_POLY[7:0]) : {x[6:0], 1'b0};
        end
        return p;
    endfunction

    function automatic logic [7:0] gf_pow2(input int e);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 0; i < e; i++) r = gf_mul(r, 8'h02);
        return r;
    endfunction

    state_t            state_q, state_nxt;
    logic [7:0]        syn_q   [NSYM];
    logic [7:0]        syn_nxt [NSYM];
    logic [NSYM*8-1:0] syn_pack;
    logic [BC_W-1:0]   beat_cnt, beat_inc;
    logic              accept, out_hs, frame_end, frame_err_nxt;

    assign out_valid     = (state_q == HOLD);
    assign in_ready      = rst_n & ((state_q == ACCUM) | out_ready);
    assign accept        = in_valid & in_ready;
    assign out_hs        = out_valid & out_ready;
    assign beat_inc      = beat_cnt + BC_W'(1);
    assign frame_end     = accept & (in_last | (beat_inc == BC_W'(BEATS)));
    assign frame_err_nxt = in_last ? (beat_inc != BC_W'(BEATS)) : (beat_inc == BC_W'(BEATS));

    // Symbol-by-symbol Horner: equivalent to S*alpha^(j*B) ^ sum d_k*alpha^(j*(B-1-k)).
    always_comb begin
        logic [7:0] acc_v;
        acc_v    = '0;
        syn_pack = '0;
        for (int j = 0; j < NSYM; j++) begin
            acc_v = syn_q[j];
            for (int k = 0; k < BEAT_SYMS; k++) begin
                acc_v = gf_mul(acc_v, gf_pow2(j + 1)) ^ in_data[(BEAT_SYMS-k)*8-1 -: 8];
            end
            syn_nxt[j] = acc_v;
            syn_pack[(NSYM-1-j)*8 +: 8] = acc_v;
        end
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ACCUM:   if (frame_end) state_nxt = HOLD;
            HOLD:    if (out_hs && !frame_end) state_nxt = ACCUM;
            default: state_nxt = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ACCUM;
            beat_cnt       <= '0;
            syndrome_out   <= '0;
            error_flag_out <= 1'b0;
            frame_err_out  <= 1'b0;
            for (int j = 0; j < NSYM; j++) syn_q[j] <= '0;
        end else begin
            state_q <= state_nxt;
            if (frame_end) begin
                beat_cnt       <= '0;
                syndrome_out   <= syn_pack;
                error_flag_out <= |syn_pack;
                frame_err_out  <= frame_err_nxt;
                for (int j = 0; j < NSYM; j++) syn_q[j] <= '0;
            end else if (accept) begin
                beat_cnt <= beat_inc;
                for (int j = 0; j < NSYM; j++) syn_q[j] <= syn_nxt[j];
            end
        end
    end

    // Statistics count delivered results; clear wins over a coincident handshake.
    always_ff @(posedge clk) begin
        if (!rst_n || clear_in) begin
            cw_cnt_out  <= '0;
            err_cnt_out <= '0;
        end else if (out_hs) begin
            if (cw_cnt_out != '1) cw_cnt_out <= cw_cnt_out + CNT_W'(1);
            if (error_flag_out && (err_cnt_out != '1)) err_cnt_out <= err_cnt_out + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_rs_syndrome_check_stream.sv
// Bench for rs_syndrome_check_stream: random and directed codewords checked against a
// log/antilog polynomial-evaluation model, with saturating counter models for two widths.
module tb_rs_syndrome_check_stream;
    localparam int N_SYMS = 10;
    localparam int BEATS  = 5;

    logic        clk = 1'b0;
    logic        rst_n, clear_in, in_valid, in_last, out_ready;
    logic [15:0] in_data;
    logic        in_ready, out_valid, error_flag_out, frame_err_out;
    logic [15:0] syndrome_out, err_cnt_out, cw_cnt_out;
    logic        in_ready2, out_valid2, flag2, ferr2;
    logic [15:0] syn2;
    logic [1:0]  err2, cw2;

    always #5 clk = ~clk;

    rs_syndrome_check_stream #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .clear_in(clear_in), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
        .syndrome_out(syndrome_out), .error_flag_out(error_flag_out), .frame_err_out(frame_err_out),
        .err_cnt_out(err_cnt_out), .cw_cnt_out(cw_cnt_out));

    rs_syndrome_check_stream #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .clear_in(clear_in), .in_valid(in_valid), .in_ready(in_ready2),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid2), .out_ready(out_ready),
        .syndrome_out(syn2), .error_flag_out(flag2), .frame_err_out(ferr2),
        .err_cnt_out(err2), .cw_cnt_out(cw2));

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    // GF(2^8) reference via exponent/log tables
    int gexp [0:509];
    int glog [0:255];
    logic [7:0] frm [N_SYMS];

    function automatic int gmul(input int a, input int b);
        if (a == 0 || b == 0) return 0;
        return gexp[glog[a] + glog[b]];
    endfunction

    // Direct evaluation of the received polynomial of m symbols at alpha^1, alpha^2.
    function automatic logic [15:0] model_syn(input int m);
        logic [15:0] r;
        int s;
        r = '0;
        for (int j = 1; j <= 2; j++) begin
            s = 0;
            for (int i = 0; i < m; i++) s = s ^ gmul(frm[i], gexp[(j * (m - 1 - i)) % 255]);
            r[(2-j)*8 +: 8] = s[7:0];
        end
        return r;
    endfunction

    typedef struct {
        logic [15:0] syn;
        logic        ferr;
    } exp_t;
    exp_t exp_q[$];

    logic        force_ready = 1'b1;
    logic        clear_req   = 1'b0;
    int          mc, me, mc2, me2;
    logic        prev_hold;
    logic [15:0] held_syn;
    logic        held_flag, held_ferr;

    // Output side: drives out_ready/clear_in on negedges and scores every delivered result.
    always @(negedge clk) begin
        logic ordy, hs;
        exp_t e;
        if (!rst_n) begin
            exp_q.delete();
            mc = 0; me = 0; mc2 = 0; me2 = 0;
            prev_hold = 1'b0;
        end
        chk("cw_cnt", cw_cnt_out, mc);
        chk("err_cnt", err_cnt_out, me);
        chk("cw_cnt_w2", cw2, mc2);
        chk("err_cnt_w2", err2, me2);
        if (rst_n && out_valid) chk("hold_ready", in_ready, out_ready);
        if (prev_hold) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_syn", syndrome_out, held_syn);
            chk("hold_flag", error_flag_out, held_flag);
            chk("hold_ferr", frame_err_out, held_ferr);
        end
        ordy = force_ready ? 1'b1 : ($urandom_range(0, 99) < 55);
        hs = rst_n && out_valid && ordy;
        clear_in = 1'b0;
        if (hs && clear_req) begin
            clear_in  = 1'b1;
            clear_req = 1'b0;
        end
        if (hs) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("syndrome", syndrome_out, e.syn);
                chk("error_flag", error_flag_out, (e.syn != 16'h0));
                chk("frame_err", frame_err_out, e.ferr);
                chk("w2_match", {out_valid2, syn2, flag2, ferr2}, {1'b1, e.syn, (e.syn != 16'h0), e.ferr});
            end
            if (clear_in) begin
                mc = 0; me = 0; mc2 = 0; me2 = 0;
            end else begin
                if (mc < 65535) mc++;
                if (mc2 < 3) mc2++;
                if (syndrome_out != 16'h0) begin
                    if (me < 65535) me++;
                    if (me2 < 3) me2++;
                end
            end
        end else if (clear_in) begin
            mc = 0; me = 0; mc2 = 0; me2 = 0;
        end
        prev_hold = rst_n && out_valid && !ordy;
        held_syn  = syndrome_out;
        held_flag = error_flag_out;
        held_ferr = frame_err_out;
        out_ready = ordy;
    end

    task automatic send_beat(input logic [15:0] d, input logic lst, output logic ok);
        ok = 1'b0;
        @(negedge clk); #2;
        in_valid = 1'b1; in_data = d; in_last = lst;
        for (int t = 0; t < 100; t++) begin
            #1;
            if (in_ready) ok = 1'b1;
            @(posedge clk); #1;
            if (ok) break;
            @(negedge clk); #2;
        end
        in_valid = 1'b0; in_last = 1'b0; in_data = 16'($urandom);
        chk("beat_accept", ok, 1);
    endtask

    // Sends frm[0 .. 2*len-1]; in_last on the final beat when lst is set.
    task automatic send_frame(input int len, input logic lst, input logic gaps);
        logic ok;
        exp_t e;
        for (int b = 0; b < len; b++) begin
            if (gaps && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(negedge clk);
            send_beat({frm[2*b], frm[2*b+1]}, lst && (b == len - 1), ok);
        end
        e.syn  = model_syn(2 * len);
        e.ferr = !(len == BEATS && lst);
        exp_q.push_back(e);
        chk("latency", out_valid, 1);
    endtask

    task automatic zero_frm();
        for (int i = 0; i < N_SYMS; i++) frm[i] = 8'h00;
    endtask

    task automatic rand_frm();
        for (int i = 0; i < N_SYMS; i++) frm[i] = 8'($urandom);
    endtask

    task automatic drain();
        for (int t = 0; t < 200 && exp_q.size() != 0; t++) @(negedge clk);
        chk("drain", exp_q.size(), 0);
        @(negedge clk);
    endtask

    initial begin
        int x;
        logic ok;
        int len;
        x = 1;
        for (int i = 0; i < 255; i++) begin
            gexp[i] = x;
            glog[x] = i;
            x = x << 1;
            if (x & 256) x = x ^ 'h15F;
        end
        for (int i = 0; i < 255; i++) gexp[i + 255] = gexp[i];
        glog[0] = 0;

        rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = 16'hA5A5;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_syndrome", syndrome_out, 0);
        chk("rst_flags", {error_flag_out, frame_err_out}, 0);
        rst_n = 1'b1;

        // All-zero codeword, then single-symbol errors at the two lowest-order positions
        force_ready = 1'b1;
        zero_frm();
        send_frame(BEATS, 1'b1, 1'b0);
        drain();
        zero_frm(); frm[9] = 8'h01;
        send_frame(BEATS, 1'b1, 1'b0);
        chk("sym9_model", model_syn(10), 16'h0101);
        zero_frm(); frm[8] = 8'h01;
        send_frame(BEATS, 1'b1, 1'b0);
        chk("sym8_model", model_syn(10), 16'h0204);
        drain();

        // Back-to-back frames under random backpressure
        force_ready = 1'b0;
        for (int f = 0; f < 6; f++) begin
            rand_frm();
            send_frame(BEATS, 1'b1, 1'b0);
        end
        drain();

        // Early in_last, then missing in_last, then a clean frame
        rand_frm();
        send_frame(3, 1'b1, 1'b0);
        rand_frm();
        send_frame(BEATS, 1'b0, 1'b0);
        rand_frm();
        send_frame(BEATS, 1'b1, 1'b0);
        drain();

        // Reset after two beats: partial frame must vanish
        rand_frm();
        send_beat({frm[0], frm[1]}, 1'b0, ok);
        send_beat({frm[2], frm[3]}, 1'b0, ok);
        @(negedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk); #1;
        rst_n = 1'b1;
        for (int t = 0; t < 6; t++) begin
            @(negedge clk); #3;
            chk("no_result_after_rst", out_valid, 0);
        end
        rand_frm();
        send_frame(BEATS, 1'b1, 1'b1);
        drain();

        // Erroneous frames to saturate the narrow counters, then clear with a handshake
        force_ready = 1'b1;
        for (int f = 0; f < 5; f++) begin
            zero_frm(); frm[9] = 8'($urandom_range(1, 255));
            send_frame(BEATS, 1'b1, 1'b0);
        end
        drain();
        chk("err_sat_w2", err2, 2'b11);
        chk("cw_sat_w2", cw2, 2'b11);
        clear_req = 1'b1;
        zero_frm(); frm[4] = 8'h33;
        send_frame(BEATS, 1'b1, 1'b0);
        for (int t = 0; t < 50 && clear_req; t++) @(negedge clk);
        chk("clear_applied", clear_req, 0);
        @(posedge clk); #1;
        chk("clear_cw", cw_cnt_out, 0);
        chk("clear_err", err_cnt_out, 0);
        chk("clear_err_w2", err2, 0);
        drain();

        // Random soak: mixed lengths, gaps, backpressure
        force_ready = 1'b0;
        for (int f = 0; f < 40; f++) begin
            rand_frm();
            if ($urandom_range(0, 4) == 0) frm[$urandom_range(0, 9)] = 8'h00;
            len = $urandom_range(1, BEATS);
            if (len < BEATS) send_frame(len, 1'b1, 1'b1);
            else send_frame(BEATS, ($urandom_range(0, 5) != 0), 1'b1);
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
